// File: rtl/fifo_wr_arb_if.sv
// Producer-side handshake bundle for the FIFO write arbiter.
// Each requester i owns bit i of valid/ready and bits [i*DW +: DW] of data.
interface fifo_wr_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int DW      = 128
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*DW-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;

  // Producers drive valid/data and observe ready.
  modport master (
    output req_valid,
    output req_data,
    input  req_ready
  );

  // The arbiter observes valid/data and drives ready.
  modport slave (
    input  req_valid,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter in front of the 128-bit FIFO.
// Grants one producer at a time for up to MAX_BURST beats. Writes reach the
// FIFO one cycle after acceptance. A credit counter, charged at accept time,
// keeps the FIFO from ever being written while full.
module fifo_wr_arb #(
  parameter  int NUM_REQ   = 4,
  parameter  int DEPTH     = 16,
  parameter  int MAX_BURST = 4,
  parameter  int DW        = 128,
  localparam int GW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int OW        = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rstn,
  fifo_wr_arb_if.slave      req_if,
  input  logic              rd_pop,
  output logic              fifo_wren,
  output logic [DW-1:0]     fifo_wrdata,
  output logic [GW-1:0]     grant_id,
  output logic              busy,
  output logic [OW-1:0]     occupancy,
  output logic              err_underflow
);

  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] grant, grant_nxt;
  logic [GW-1:0] rr_ptr, rr_ptr_nxt;
  logic [BW-1:0] beat_cnt, beat_cnt_nxt;
  logic [OW-1:0] occ;

  logic [GW-1:0]      pick_idx;
  logic               pick_found;
  logic [GW-1:0]      grant_inc;
  logic               has_credit;
  logic               accept;
  logic               pop_ok;
  logic [NUM_REQ-1:0] ready_vec;

  // Ready depends only on registered state, so rd_pop never reaches it combinationally.
  assign has_credit = (occ < OW'(DEPTH));
  assign accept     = (state == BURST) && req_if.req_valid[grant] && has_credit;
  assign pop_ok     = rd_pop && (occ != '0);
  assign grant_inc  = (grant == GW'(NUM_REQ - 1)) ? '0 : grant + GW'(1);

  assign req_if.req_ready = ready_vec;
  assign grant_id         = grant;
  assign busy             = (state == BURST);
  assign occupancy        = occ;

  // Search for the first valid requester starting at rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    logic [GW-1:0] cand;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = GW'((int'(rr_ptr) + k) % NUM_REQ);
      if (!pick_found && req_if.req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Only the current grantee sees ready, and only while credit remains.
  always_comb begin
    ready_vec = '0;
    if ((state == BURST) && has_credit) begin
      ready_vec[grant] = 1'b1;
    end
  end

  // Next-state logic: arbitrate in IDLE, count beats and release the grant in BURST.
  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    rr_ptr_nxt   = rr_ptr;
    beat_cnt_nxt = beat_cnt;
    case (state)
      IDLE: begin
        if (pick_found) begin
          grant_nxt    = pick_idx;
          beat_cnt_nxt = '0;
          state_nxt    = BURST;
        end
      end
      BURST: begin
        if (!req_if.req_valid[grant]) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = grant_inc;
        end else if (accept) begin
          beat_cnt_nxt = beat_cnt + BW'(1);
          if (beat_cnt == BW'(MAX_BURST - 1)) begin
            state_nxt  = IDLE;
            rr_ptr_nxt = grant_inc;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state    <= IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      rr_ptr   <= rr_ptr_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  // Registered FIFO write port; data holds its last value between writes.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      fifo_wren   <= 1'b0;
      fifo_wrdata <= '0;
    end else begin
      fifo_wren <= accept;
      if (accept) begin
        fifo_wrdata <= req_if.req_data[int'(grant)*DW +: DW];
      end
    end
  end

  // Credit counter charged at accept; a pop on an empty count flags a sticky underflow.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      occ           <= '0;
      err_underflow <= 1'b0;
    end else begin
      if (rd_pop && (occ == '0)) begin
        err_underflow <= 1'b1;
      end
      case ({accept, pop_ok})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: doc/fifo_wr_arb.md
# fifo_wr_arb

Round-robin write arbiter for the 128-bit FIFO. Up to NUM_REQ producers present beats on valid/ready handshakes. The arbiter grants one producer at a time for a bounded burst and drives the FIFO write port (write enable plus 128-bit data) from registers. It tracks FIFO occupancy with an internal credit counter, so no beat is ever written into a full FIFO.

## Interface
- NUM_REQ, default 4: number of requesters, 2..8.
- DEPTH, default 16: FIFO depth in entries; the credit ceiling.
- MAX_BURST, default 4: maximum beats per grant, ≥1.
- DW, default 128: data width.
- clk  in  1  clock; all logic on posedge.
- rstn  in  1  reset, asynchronous, active-high (asserted = 1 clears all state).
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_data  in  NUM_REQ*DW  per-requester data; requester i occupies bits [i*DW +: DW].
- req_ready  out  NUM_REQ  per-requester accept.
- rd_pop  in  1  FIFO read actually performed this cycle (i_rden && !o_empty), supplied by the consumer side.
- fifo_wren  out  1  FIFO write enable (drives i_wren).
- fifo_wrdata  out  DW  FIFO write data (drives i_wrdata).
- grant_id  out  clog2(NUM_REQ)  current grantee index.
- busy  out  1  high while in BURST.
- occupancy  out  clog2(DEPTH+1)  credited entries.
- err_underflow  out  1  sticky: rd_pop seen while occupancy == 0.

## Operation
- State machine has two states, IDLE and BURST, plus a registered grant, a beat counter beat_cnt, and a round-robin pointer rr_ptr.
- IDLE:
  - If any req_valid bit is set, the arbiter loads grant with the first valid index searching rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - It clears beat_cnt and moves to BURST.
  - Otherwise it stays in IDLE.
- BURST:
  - req_ready[grant] = (occupancy < DEPTH). All other req_ready bits are 0.
  - accept = req_valid[grant] && req_ready[grant].
  - On accept: beat_cnt increments. If beat_cnt == MAX_BURST-1, go to IDLE and set rr_ptr = grant+1 (mod NUM_REQ).
  - If req_valid[grant] == 0: go to IDLE and set rr_ptr = grant+1. The grant is released.
  - If occupancy == DEPTH and req_valid[grant] == 1: hold the grant and stay in BURST. No timeout applies.
- Write port: registered. fifo_wren <= accept; fifo_wrdata <= req_data[grant] on accept, else it holds its previous value.
- occupancy: next = occupancy + accept − rd_pop.
  - Credit is taken at accept, not at fifo_wren, so the beat in flight is already counted.
  - When accept and rd_pop occur together, occupancy is unchanged.
  - rd_pop while occupancy == 0: occupancy stays 0 and err_underflow sets. err_underflow clears only on reset.
- req_ready does not depend on rd_pop, so there is no combinational path from rd_pop to req_ready. A pop arriving while occupancy == DEPTH opens ready in the next cycle.
- Reset values: state IDLE, grant_id 0, rr_ptr 0, beat_cnt 0, occupancy 0, req_ready all 0, fifo_wren 0, fifo_wrdata 0, busy 0, err_underflow 0.

## Timing
- Arbitration costs one cycle. A request raised at cycle t in IDLE gives req_ready high at t+1, if occupancy < DEPTH.
- Accept at cycle t produces fifo_wren = 1 with the data at t+1. Write latency is one cycle.
- Back-to-back bursts: after a burst ends, there is one IDLE cycle before the next grant. Peak throughput is MAX_BURST beats per MAX_BURST+1 cycles.
- Within a burst, one beat may be accepted per cycle.
- req_ready is a combinational decode of registered state, grant and occupancy.
- Reset asserted mid-burst:
  - All outputs take their reset values immediately, asynchronously.
  - A beat accepted in the cycle before reset does not produce fifo_wren.
  - The FIFO must be reset in the same domain.
- rr_ptr wraps from NUM_REQ-1 to 0.

## Test plan
- Single burst: NUM_REQ=4, DEPTH=16, MAX_BURST=4; req 2 valid continuously with data 0xA0..0xA5.
  - Grant to 2 at cycle 1.
  - fifo_wren pulses 4 times carrying 0xA0..0xA3, then one IDLE cycle.
  - Re-grant to 2, then 0xA4 and 0xA5 follow.
- Fairness: all 4 requesters valid continuously. Grant sequence is 0,1,2,3,0, each holding exactly 4 beats; grant_id matches the source of fifo_wrdata.
- Full backpressure: one requester streams with no rd_pop.
  - occupancy reaches 16, then req_ready drops and fifo_wren stops after exactly 16 writes.
  - A single rd_pop pulse gives req_ready = 1 in the next cycle, and occupancy returns to 16.
- Simultaneous events: occupancy = 8 with accept and rd_pop in the same cycle → occupancy stays 8. A rd_pop pulse from reset (occupancy 0) → err_underflow = 1 and occupancy stays 0.
- Early release: req 1 drops valid after 2 of 4 beats while req 3 is waiting. Release occurs, then one IDLE cycle, then grant to 3.
- Reset mid-burst: assert rstn during beat 2 of a burst.
  - All outputs read 0 during reset.
  - After release, the first grant goes to the lowest valid index from rr_ptr = 0.
